// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the count_ctrl run/pause/load controller.
package count_ctrl_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  function automatic logic bcd_ok(input logic [DIGIT_W-1:0] v);
    return v <= MAX_DIGIT;
  endfunction

endpackage

// File: rtl/count_ctrl_if.sv
// Control bus from count_ctrl to the downstream BCD counter.
interface count_ctrl_if;
  import count_ctrl_pkg::*;

  logic               cnt_en;
  logic               ud;
  logic [DIGIT_W-1:0] start_vl;
  logic [DIGIT_W-1:0] stop_vl;
  logic               load;

  modport master (output cnt_en, output ud, output start_vl, output stop_vl, output load);
  modport slave  (input  cnt_en, input  ud, input  start_vl, input  stop_vl, input  load);
endinterface

// File: rtl/count_ctrl_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, rising-edge press pulse.
module count_ctrl_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level flips only after DEB_CYCLES consecutive cycles of disagreement.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/count_ctrl.sv
// Run/pause/load controller producing count ticks and range bounds for a BCD counter.
// Optional build macro COUNT_CTRL_UD_LOCK_EN freezes the direction while running.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_run,
  input  logic               btn_load,
  input  logic               sw_ud,
  input  logic [DIGIT_W-1:0] sw_start,
  input  logic [DIGIT_W-1:0] sw_stop,
  count_ctrl_if.master       cnt_if,
  output logic [1:0]         state,
  output logic               cfg_err
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic run_press, load_press;

  count_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clk(clk), .rst(rst), .btn_raw(btn_run), .press(run_press)
  );

  count_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .clk(clk), .rst(rst), .btn_raw(btn_load), .press(load_press)
  );

  logic               ud_s1_q, ud_s2_q;
  logic [DIGIT_W-1:0] start_s1_q, start_s2_q, stop_s1_q, stop_s2_q;

  state_e             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [DIGIT_W-1:0] start_q, start_d, stop_q, stop_d;
  logic               ud_q, ud_d;
  logic               cnt_en_q, cnt_en_d;
  logic               load_q, load_d;
  logic               cfg_err_q, cfg_err_d;
  logic               load_take;

  // Switch synchronizers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ud_s1_q    <= 1'b0;
      ud_s2_q    <= 1'b0;
      start_s1_q <= '0;
      start_s2_q <= '0;
      stop_s1_q  <= '0;
      stop_s2_q  <= '0;
    end else begin
      ud_s1_q    <= sw_ud;
      ud_s2_q    <= ud_s1_q;
      start_s1_q <= sw_start;
      start_s2_q <= start_s1_q;
      stop_s1_q  <= sw_stop;
      stop_s2_q  <= stop_s1_q;
    end
  end

  // Next state, config latch and prescaler; load has priority outside RUN, run inside it.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    start_d   = start_q;
    stop_d    = stop_q;
    cfg_err_d = cfg_err_q;
    load_d    = 1'b0;
    cnt_en_d  = 1'b0;
    load_take = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_press)     load_take = 1'b1;
        else if (run_press) state_d   = RUN;
      end
      RUN: begin
        if (run_press) state_d = PAUSE;
      end
      PAUSE: begin
        if (load_press) begin
          load_take = 1'b1;
          state_d   = IDLE;
        end else if (run_press) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_take) begin
      if (bcd_ok(start_s2_q) && bcd_ok(stop_s2_q)) begin
        start_d   = start_s2_q;
        stop_d    = stop_s2_q;
        cfg_err_d = 1'b0;
        load_d    = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    // Fresh start clears phase; pause and resume edges leave it untouched.
    if (state_q == IDLE && state_d == RUN) begin
      presc_d = '0;
    end else if (state_q == RUN && state_d == RUN) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    end
    cnt_en_d = (state_d == RUN) && (presc_d == PRESC_MAX);

`ifdef COUNT_CTRL_UD_LOCK_EN
    ud_d = (state_q == RUN) ? ud_q : ud_s2_q;
`else
    ud_d = ud_s2_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      start_q   <= '0;
      stop_q    <= MAX_DIGIT;
      ud_q      <= 1'b0;
      cnt_en_q  <= 1'b0;
      load_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      ud_q      <= ud_d;
      cnt_en_q  <= cnt_en_d;
      load_q    <= load_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cnt_if.cnt_en   = cnt_en_q;
  assign cnt_if.ud       = ud_q;
  assign cnt_if.start_vl = start_q;
  assign cnt_if.stop_vl  = stop_q;
  assign cnt_if.load     = load_q;
  assign state           = state_q;
  assign cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl with TICK_DIV=4, DEB_CYCLES=3; inputs driven on falling edges.
module tb_count_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_run, btn_load, sw_ud;
  logic [3:0] sw_start, sw_stop;
  logic [1:0] state;
  logic       cfg_err;
  int         n_vec = 0;
  int         n_err = 0;

  count_ctrl_if bus ();

  count_ctrl #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_load(btn_load), .sw_ud(sw_ud),
    .sw_start(sw_start), .sw_stop(sw_stop), .cnt_if(bus), .state(state), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Hold buttons 6 cycles: sync(2) + debounce(3) + FSM edge; returns one sample after the FSM edge.
  task automatic press(input logic r, input logic l, output int loads);
    loads    = 0;
    btn_run  = r;
    btn_load = l;
    repeat (6) begin
      @(negedge clk);
      if (bus.load === 1'b1) loads++;
    end
    btn_run  = 1'b0;
    btn_load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; btn_run = 1'b0; btn_load = 1'b0; sw_ud = 1'b0; sw_start = 4'd0; sw_stop = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (state !== 2'd0)        begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
    n_vec++; if (bus.start_vl !== 4'd0) begin n_err++; $display("FAIL reset_start got %0d want 0", bus.start_vl); end
    n_vec++; if (bus.stop_vl !== 4'd9)  begin n_err++; $display("FAIL reset_stop got %0d want 9", bus.stop_vl); end
    n_vec++; if (bus.ud !== 1'b0)       begin n_err++; $display("FAIL reset_ud got %0b want 0", bus.ud); end
    n_vec++; if (bus.cnt_en !== 1'b0)   begin n_err++; $display("FAIL reset_cnt_en got %0b want 0", bus.cnt_en); end
    n_vec++; if (bus.load !== 1'b0)     begin n_err++; $display("FAIL reset_load got %0b want 0", bus.load); end
    n_vec++; if (cfg_err !== 1'b0)      begin n_err++; $display("FAIL reset_cfg_err got %0b want 0", cfg_err); end
  endtask

  task automatic test_glitch;
    btn_run = 1'b1;
    repeat (2) @(negedge clk);
    btn_run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL glitch_state cyc %0d got %0d want 0", i, state); end
    end
  endtask

  // Start, 12 RUN cycles of ticks, pause with prescaler at 1, 20 idle cycles, resume.
  task automatic test_run_pause;
    int pulses, ld;
    btn_run = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL run_early got %0d want 0", state); end
    @(negedge clk);
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL run_entry got %0d want 1", state); end
    btn_run = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.cnt_en === 1'b1) pulses++;
      n_vec++; if (bus.cnt_en !== ((i % 4) == 3)) begin n_err++; $display("FAIL tick cyc %0d got %0b want %0b", i, bus.cnt_en, (i % 4) == 3); end
      @(negedge clk);
    end
    n_vec++; if (pulses != 3) begin n_err++; $display("FAIL tick_count got %0d want 3", pulses); end
    press(1'b1, 1'b0, ld);
    n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL pause_entry got %0d want 2", state); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++; if (state !== 2'd2 || bus.cnt_en !== 1'b0) begin n_err++; $display("FAIL pause_hold cyc %0d state %0d cnt_en %0b want 2/0", i, state, bus.cnt_en); end
    end
    press(1'b1, 1'b0, ld);
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL resume_state got %0d want 1", state); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (bus.cnt_en !== (i == 2)) begin n_err++; $display("FAIL resume_tick cyc %0d got %0b want %0b", i, bus.cnt_en, i == 2); end
      @(negedge clk);
    end
  endtask

  task automatic test_load_in_run;
    int ld;
    sw_start = 4'd5; sw_stop = 4'd6;
    repeat (4) @(negedge clk);
    press(1'b0, 1'b1, ld);
    n_vec++; if (ld != 0)               begin n_err++; $display("FAIL run_load_pulse got %0d want 0", ld); end
    n_vec++; if (state !== 2'd1)        begin n_err++; $display("FAIL run_load_state got %0d want 1", state); end
    n_vec++; if (bus.start_vl !== 4'd0) begin n_err++; $display("FAIL run_load_start got %0d want 0", bus.start_vl); end
    repeat (6) @(negedge clk);
    press(1'b1, 1'b1, ld);
    n_vec++; if (state !== 2'd2)        begin n_err++; $display("FAIL simul_run_state got %0d want 2", state); end
    n_vec++; if (ld != 0)               begin n_err++; $display("FAIL simul_run_load got %0d want 0", ld); end
    n_vec++; if (bus.stop_vl !== 4'd9)  begin n_err++; $display("FAIL simul_run_stop got %0d want 9", bus.stop_vl); end
  endtask

  task automatic test_load_valid;
    int ld;
    sw_start = 4'd3; sw_stop = 4'd7;
    repeat (6) @(negedge clk);
    press(1'b0, 1'b1, ld);
    n_vec++; if (state !== 2'd0)        begin n_err++; $display("FAIL load_state got %0d want 0", state); end
    n_vec++; if (bus.start_vl !== 4'd3) begin n_err++; $display("FAIL load_start got %0d want 3", bus.start_vl); end
    n_vec++; if (bus.stop_vl !== 4'd7)  begin n_err++; $display("FAIL load_stop got %0d want 7", bus.stop_vl); end
    n_vec++; if (bus.load !== 1'b1)     begin n_err++; $display("FAIL load_pulse got %0b want 1", bus.load); end
    n_vec++; if (ld != 1)               begin n_err++; $display("FAIL load_pulse_count got %0d want 1", ld); end
    @(negedge clk);
    n_vec++; if (bus.load !== 1'b0)     begin n_err++; $display("FAIL load_pulse_end got %0b want 0", bus.load); end
  endtask

  task automatic test_load_invalid;
    int ld;
    sw_start = 4'd12; sw_stop = 4'd4;
    repeat (6) @(negedge clk);
    press(1'b0, 1'b1, ld);
    n_vec++; if (cfg_err !== 1'b1)      begin n_err++; $display("FAIL bad_cfg_err got %0b want 1", cfg_err); end
    n_vec++; if (bus.start_vl !== 4'd3) begin n_err++; $display("FAIL bad_start got %0d want 3", bus.start_vl); end
    n_vec++; if (bus.stop_vl !== 4'd7)  begin n_err++; $display("FAIL bad_stop got %0d want 7", bus.stop_vl); end
    n_vec++; if (ld != 0)               begin n_err++; $display("FAIL bad_load got %0d want 0", ld); end
  endtask

  // Both buttons in IDLE with bounds at the digit limits: load must win.
  task automatic test_simul_idle;
    int ld;
    sw_start = 4'd9; sw_stop = 4'd0;
    repeat (6) @(negedge clk);
    press(1'b1, 1'b1, ld);
    n_vec++; if (state !== 2'd0)        begin n_err++; $display("FAIL simul_idle_state got %0d want 0", state); end
    n_vec++; if (bus.start_vl !== 4'd9) begin n_err++; $display("FAIL edge_start got %0d want 9", bus.start_vl); end
    n_vec++; if (bus.stop_vl !== 4'd0)  begin n_err++; $display("FAIL edge_stop got %0d want 0", bus.stop_vl); end
    n_vec++; if (cfg_err !== 1'b0)      begin n_err++; $display("FAIL edge_cfg_err got %0b want 0", cfg_err); end
    n_vec++; if (ld != 1)               begin n_err++; $display("FAIL simul_idle_load got %0d want 1", ld); end
  endtask

  task automatic test_ud;
    sw_ud = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.ud !== 1'b0) begin n_err++; $display("FAIL ud_early got %0b want 0", bus.ud); end
    @(negedge clk);
    n_vec++; if (bus.ud !== 1'b1) begin n_err++; $display("FAIL ud_follow got %0b want 1", bus.ud); end
  endtask

  // Reset lands on the edge where a tick would have fired.
  task automatic test_reset_in_run;
    int ld;
    repeat (6) @(negedge clk);
    press(1'b1, 1'b0, ld);
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL rr_run got %0d want 1", state); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (state !== 2'd0)        begin n_err++; $display("FAIL rr_state got %0d want 0", state); end
    n_vec++; if (bus.start_vl !== 4'd0) begin n_err++; $display("FAIL rr_start got %0d want 0", bus.start_vl); end
    n_vec++; if (bus.stop_vl !== 4'd9)  begin n_err++; $display("FAIL rr_stop got %0d want 9", bus.stop_vl); end
    n_vec++; if (bus.ud !== 1'b0)       begin n_err++; $display("FAIL rr_ud got %0b want 0", bus.ud); end
    n_vec++; if (bus.cnt_en !== 1'b0)   begin n_err++; $display("FAIL rr_cnt_en got %0b want 0", bus.cnt_en); end
    n_vec++; if (bus.load !== 1'b0)     begin n_err++; $display("FAIL rr_load got %0b want 0", bus.load); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.cnt_en !== 1'b0 || bus.load !== 1'b0) begin n_err++; $display("FAIL rr_after cnt_en %0b load %0b want 0/0", bus.cnt_en, bus.load); end
    n_vec++; if (state !== 2'd0)        begin n_err++; $display("FAIL rr_after_state got %0d want 0", state); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_run_pause();
    test_load_in_run();
    test_load_valid();
    test_load_invalid();
    test_simul_idle();
    test_ud();
    test_reset_in_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
